// File: rtl/intersection_phase_scheduler_if.sv
// Handshake bundle between the intersection scheduler and its environment:
// detector/button/override inputs and the per-approach light codes.
interface intersection_phase_scheduler_if;
  logic       ns_req;
  logic       ew_req;
  logic       ped_req;
  logic       manual_override;
  logic [1:0] manual_state;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output ns_req, ew_req, ped_req, manual_override, manual_state,
    input  ns_light, ew_light, walk, ped_ack, phase
  );

  modport slave (
    input  ns_req, ew_req, ped_req, manual_override, manual_state,
    output ns_light, ew_light, walk, ped_ack, phase
  );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Two-approach intersection phase scheduler with all-red clearance and manual override.
// Optional pedestrian walk phase is built when PED_PHASE_EN is defined.
module intersection_phase_scheduler #(
  parameter int unsigned GREEN_CYCLES  = 20,
  parameter int unsigned MIN_GREEN     = 8,
  parameter int unsigned YELLOW_CYCLES = 4,
  parameter int unsigned ALLRED_CYCLES = 2,
  parameter int unsigned WALK_CYCLES   = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  intersection_phase_scheduler_if.slave bus
);

  localparam int unsigned MAX_A   = (GREEN_CYCLES > MIN_GREEN) ? GREEN_CYCLES : MIN_GREEN;
  localparam int unsigned MAX_B   = (YELLOW_CYCLES > ALLRED_CYCLES) ? YELLOW_CYCLES : ALLRED_CYCLES;
  localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_P   = (MAX_C > WALK_CYCLES) ? MAX_C : WALK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_P) + 1;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_ALLRED_A  = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_ALLRED_B  = 3'd5,
    S_PED_WALK  = 3'd6,
    S_MANUAL    = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_cap;
  logic               own_req, cross_req, demand, green_done;
  logic               walk_entry;
  logic               ped_pend_c, next_ew_c;
  logic [1:0]         ns_light_d, ew_light_d;
  logic               walk_d, ped_ack_d;

`ifdef PED_PHASE_EN
  logic ped_pend_q, ped_pend_d;
  logic next_ew_q, next_ew_d;

  assign ped_pend_c = ped_pend_q;
  assign next_ew_c  = next_ew_q;

  // Entry into the walk phase clears the latched request and records which green resumes.
  always_comb begin
    ped_pend_d = ped_pend_q | bus.ped_req;
    next_ew_d  = next_ew_q;
    if (walk_entry) begin
      ped_pend_d = 1'b0;
      next_ew_d  = (state_q == S_ALLRED_A);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ped_pend_q <= 1'b0;
      next_ew_q  <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      next_ew_q  <= next_ew_d;
    end
  end
`else
  logic unused_ped_req;

  assign unused_ped_req = bus.ped_req;
  assign ped_pend_c     = 1'b0;
  assign next_ew_c      = 1'b0;
`endif

  // State register and phase counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ALLRED_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; override beats every normal transition.
  always_comb begin
    state_d    = state_q;
    own_req    = 1'b0;
    cross_req  = 1'b0;
    if (state_q == S_NS_GREEN) begin
      own_req   = bus.ns_req;
      cross_req = bus.ew_req;
    end else if (state_q == S_EW_GREEN) begin
      own_req   = bus.ew_req;
      cross_req = bus.ns_req;
    end
    demand     = cross_req | ped_pend_c;
    green_done = demand &&
                 ((!own_req && (cnt_q >= CNT_W'(MIN_GREEN - 1))) ||
                  (cnt_q >= CNT_W'(GREEN_CYCLES - 1)));

    unique case (state_q)
      S_NS_GREEN:  if (green_done) state_d = S_NS_YELLOW;
      S_NS_YELLOW: if (cnt_q >= CNT_W'(YELLOW_CYCLES - 1)) state_d = S_ALLRED_A;
      S_ALLRED_A:  if (cnt_q >= CNT_W'(ALLRED_CYCLES - 1))
                     state_d = ped_pend_c ? S_PED_WALK : S_EW_GREEN;
      S_EW_GREEN:  if (green_done) state_d = S_EW_YELLOW;
      S_EW_YELLOW: if (cnt_q >= CNT_W'(YELLOW_CYCLES - 1)) state_d = S_ALLRED_B;
      S_ALLRED_B:  if (cnt_q >= CNT_W'(ALLRED_CYCLES - 1))
                     state_d = ped_pend_c ? S_PED_WALK : S_NS_GREEN;
      S_PED_WALK:  if (cnt_q >= CNT_W'(WALK_CYCLES - 1))
                     state_d = next_ew_c ? S_EW_GREEN : S_NS_GREEN;
      S_MANUAL:    state_d = S_ALLRED_B;
      default:     state_d = S_ALLRED_B;
    endcase

    if (bus.manual_override) state_d = S_MANUAL;

    // Green rests with the counter pinned at the max-green threshold.
    cnt_cap = ((state_q == S_NS_GREEN) || (state_q == S_EW_GREEN)) ?
              CNT_W'(GREEN_CYCLES - 1) : '1;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != cnt_cap) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign walk_entry = (state_d == S_PED_WALK) && (state_q != S_PED_WALK);

  // Output decode of the state being entered, so lights change on the entry edge.
  always_comb begin
    ns_light_d = LIGHT_RED;
    ew_light_d = LIGHT_RED;
    walk_d     = 1'b0;
    ped_ack_d  = 1'b0;
    unique case (state_d)
      S_NS_GREEN:  ns_light_d = LIGHT_GREEN;
      S_NS_YELLOW: ns_light_d = LIGHT_YELLOW;
      S_EW_GREEN:  ew_light_d = LIGHT_GREEN;
      S_EW_YELLOW: ew_light_d = LIGHT_YELLOW;
      S_MANUAL:    ns_light_d = (bus.manual_state == 2'b11) ? LIGHT_RED : bus.manual_state;
      default:     ns_light_d = LIGHT_RED;
    endcase
`ifdef PED_PHASE_EN
    walk_d    = (state_d == S_PED_WALK);
    ped_ack_d = walk_entry;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ns_light <= LIGHT_RED;
      bus.ew_light <= LIGHT_RED;
      bus.walk     <= 1'b0;
      bus.ped_ack  <= 1'b0;
    end else begin
      bus.ns_light <= ns_light_d;
      bus.ew_light <= ew_light_d;
      bus.walk     <= walk_d;
      bus.ped_ack  <= ped_ack_d;
    end
  end

  assign bus.phase = state_q;

  // Safety: never two approaches non-red at once; walk only with all lights red.
  a_no_conflict: assert property (@(posedge clk) disable iff (reset)
    !((bus.ns_light != LIGHT_RED) && (bus.ew_light != LIGHT_RED)));
  a_walk_all_red: assert property (@(posedge clk) disable iff (reset)
    bus.walk |-> ((bus.ns_light == LIGHT_RED) && (bus.ew_light == LIGHT_RED)));

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Randomized + directed bench for intersection_phase_scheduler against a cycle-level
// behavioural model of the phase rules; honours PED_PHASE_EN like the design.
module tb_intersection_phase_scheduler;

  localparam int GREEN_CYCLES  = 20;
  localparam int MIN_GREEN     = 8;
  localparam int YELLOW_CYCLES = 4;
  localparam int ALLRED_CYCLES = 2;
  localparam int WALK_CYCLES   = 10;
`ifdef PED_PHASE_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic ns_req, ew_req, ped_req, ovr;
  logic [1:0] ms;

  int n_cmp = 0;
  int n_err = 0;

  intersection_phase_scheduler_if bus_if ();
  assign bus_if.ns_req          = ns_req;
  assign bus_if.ew_req          = ew_req;
  assign bus_if.ped_req         = ped_req;
  assign bus_if.manual_override = ovr;
  assign bus_if.manual_state    = ms;

  intersection_phase_scheduler #(
    .GREEN_CYCLES (GREEN_CYCLES),
    .MIN_GREEN    (MIN_GREEN),
    .YELLOW_CYCLES(YELLOW_CYCLES),
    .ALLRED_CYCLES(ALLRED_CYCLES),
    .WALK_CYCLES  (WALK_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // Model: phase number, cycles already spent in it, pedestrian latch, resume side.
  int m_ph = 5, m_el = 0;
  bit m_pend = 0, m_nextew = 0, m_walk = 0, m_ack = 0;
  int m_ns = 0, m_ew = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit ns, input bit ew, input bit ped,
                            input bit ov, input bit [1:0] mst);
    int nx, spent;
    bit own, dem;
    if (r) begin
      m_ph = 5; m_el = 0; m_pend = 0; m_nextew = 0;
      m_ns = 0; m_ew = 0; m_walk = 0; m_ack = 0;
      return;
    end
    spent = m_el + 1;
    nx = m_ph;
    if (ov) nx = 7;
    else case (m_ph)
      0, 3: begin
        own = (m_ph == 0) ? ns : ew;
        dem = ((m_ph == 0) ? ew : ns) | (PED_EN & m_pend);
        if (dem && ((!own && spent >= MIN_GREEN) || spent >= GREEN_CYCLES)) nx = m_ph + 1;
      end
      1, 4: if (spent == YELLOW_CYCLES) nx = m_ph + 1;
      2, 5: if (spent == ALLRED_CYCLES) nx = (PED_EN && m_pend) ? 6 : ((m_ph == 2) ? 3 : 0);
      6:    if (spent == WALK_CYCLES) nx = m_nextew ? 3 : 0;
      default: nx = 5;
    endcase
    m_ack = (nx == 6) && (m_ph != 6);
    if (m_ack) begin
      m_nextew = (m_ph == 2);
      m_pend   = 0;
    end else if (PED_EN) begin
      m_pend = m_pend | ped;
    end
    m_el = (nx == m_ph) ? spent : 0;
    m_ph = nx;
    m_ns = (m_ph == 0) ? 2 : (m_ph == 1) ? 1 : (m_ph == 7) ? ((mst == 2'b11) ? 0 : int'(mst)) : 0;
    m_ew = (m_ph == 3) ? 2 : (m_ph == 4) ? 1 : 0;
    m_walk = (m_ph == 6);
  endtask

  // One clock: model consumes the inputs the DUT sampled, outputs compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step(rst, ns_req, ew_req, ped_req, ovr, ms);
    #1;
    check("phase",   int'(bus_if.phase),    m_ph);
    check("ns",      int'(bus_if.ns_light), m_ns);
    check("ew",      int'(bus_if.ew_light), m_ew);
    check("walk",    int'(bus_if.walk),     int'(m_walk));
    check("ped_ack", int'(bus_if.ped_ack),  int'(m_ack));
    check("overlap", int'((bus_if.ns_light != 2'b00) && (bus_if.ew_light != 2'b00)), 0);
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int n = 0;
    while (int'(bus_if.phase) != ph && n < budget) begin
      cycle();
      n++;
    end
    check("wait_phase", int'(bus_if.phase), ph);
  endtask

  // Length of the current run of phase ph, counting the already-observed first cycle.
  task automatic run_len(input int ph, output int n);
    n = 1;
    while (n < 200) begin
      cycle();
      if (int'(bus_if.phase) != ph) break;
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int n, total, sixes;
    rst = 1'b1; ns_req = 0; ew_req = 0; ped_req = 0; ovr = 0; ms = 2'b00;

    // Reset with no requests: two all-red cycles then resting NS green.
    do_reset();
    check("rst_phase", int'(bus_if.phase), 5);
    check("rst_ns", int'(bus_if.ns_light), 0);
    cycle();
    check("rst_ar2", int'(bus_if.phase), 5);
    repeat (55) cycle();
    check("rest_ns_green", int'(bus_if.ns_light), 2);
    check("rest_ew_red", int'(bus_if.ew_light), 0);

    // Cross request gapped at minimum green.
    do_reset();
    ew_req = 1'b1;
    wait_phase(0, 10);
    run_len(0, n); check("min_green_len", n, MIN_GREEN);
    run_len(1, n); check("yellow_len", n, YELLOW_CYCLES);
    run_len(2, n); check("allred_len", n, ALLRED_CYCLES);
    check("ew_green", int'(bus_if.ew_light), 2);

    // Both approaches requesting: capped greens, 52-cycle period.
    ns_req = 1'b1;
    wait_phase(0, 60);
    total = 0;
    run_len(0, n); check("max_green_ns", n, GREEN_CYCLES); total += n;
    run_len(1, n); total += n;
    run_len(2, n); total += n;
    run_len(3, n); check("max_green_ew", n, GREEN_CYCLES); total += n;
    run_len(4, n); total += n;
    run_len(5, n); total += n;
    check("period", total, 52);

`ifdef PED_PHASE_EN
    // Pedestrian pulse during EW green.
    ns_req = 1'b0;
    wait_phase(3, 80);
    ped_req = 1'b1; cycle(); ped_req = 1'b0;
    wait_phase(6, 60);
    check("ped_ack_first", int'(bus_if.ped_ack), 1);
    run_len(6, n); check("walk_len", n, WALK_CYCLES);
    check("after_walk_ns", int'(bus_if.ns_light), 2);
`endif

    // Manual override mid NS yellow.
    ns_req = 1'b0; ew_req = 1'b1;
    wait_phase(1, 100);
    cycle();
    ovr = 1'b1; ms = 2'b01;
    cycle();
    check("man_phase", int'(bus_if.phase), 7);
    check("man_ns", int'(bus_if.ns_light), 1);
    check("man_ew", int'(bus_if.ew_light), 0);
    ms = 2'b11;
    cycle();
    check("man_11", int'(bus_if.ns_light), 0);
    ovr = 1'b0; ew_req = 1'b0;
    cycle(); check("rel_ar1", int'(bus_if.phase), 5);
    cycle(); check("rel_ar2", int'(bus_if.phase), 5);
    cycle(); check("rel_ns", int'(bus_if.ns_light), 2);

`ifdef PED_PHASE_EN
    // Reset mid-walk, then no further walk without a request.
    ped_req = 1'b1; cycle(); ped_req = 1'b0;
    ew_req = 1'b1;
    wait_phase(6, 80);
    cycle(); cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rstwalk_walk", int'(bus_if.walk), 0);
    check("rstwalk_phase", int'(bus_if.phase), 5);
    sixes = 0;
    for (int i = 0; i < 150; i++) begin
      ns_req = 1'($urandom_range(0, 1));
      ew_req = 1'($urandom_range(0, 1));
      cycle();
      if (bus_if.phase == 3'd6) sixes++;
    end
    check("no_walk_after_rst", sixes, 0);
`endif

    // Randomized soak against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ns_req = ~ns_req;
      if ($urandom_range(0, 7) == 0) ew_req = ~ew_req;
      ped_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) ovr = ~ovr;
      ms = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Sequences a two-approach intersection (north-south / east-west) by driving the per-approach light codes consumed by the traffic light controllers. It arbitrates between vehicle detector requests and a pedestrian crossing request, inserts all-red clearance intervals, and gives an external manual override absolute priority. It sits directly above the per-approach light controllers and owns all phase timing.

## Interface
- `GREEN_CYCLES`, 20: maximum green length in cycles while cross demand is pending.
- `MIN_GREEN`, 8: minimum green length in cycles; must be ≤ `GREEN_CYCLES`.
- `YELLOW_CYCLES`, 4: fixed yellow length in cycles.
- `ALLRED_CYCLES`, 2: fixed all-red clearance length in cycles.
- `WALK_CYCLES`, 10: pedestrian walk phase length in cycles.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ns_req`  in  1  NS vehicle detector, level-sensitive.
- `ew_req`  in  1  EW vehicle detector, level-sensitive.
- `ped_req`  in  1  pedestrian button; a one-cycle pulse or a level, latched internally.
- `manual_override`  in  1  when high, manual control replaces automatic sequencing.
- `manual_state`  in  2  NS light code under override: 00 red, 01 yellow, 10 green, 11 treated as red.
- `ns_light`  out  2  NS light code: 00 red, 01 yellow, 10 green.
- `ew_light`  out  2  EW light code, same encoding as `ns_light`.
- `walk`  out  1  pedestrian walk indication.
- `ped_ack`  out  1  one-cycle pulse on the first cycle of a walk phase.
- `phase`  out  3  current FSM state code, for debug and scoreboarding.

## Operation
- The FSM has eight states, each with its `phase` code:
  - 0 NS_GREEN
  - 1 NS_YELLOW
  - 2 ALLRED_A (follows NS)
  - 3 EW_GREEN
  - 4 EW_YELLOW
  - 5 ALLRED_B (follows EW)
  - 6 PED_WALK
  - 7 MANUAL
- `cnt` is cleared on every state entry and increments each cycle the state is held. Its width is `$clog2` of the largest parameter, plus 1.
- `ped_pend` is set by `ped_req` and cleared on entry to PED_WALK. If `ped_req` is high in that same cycle, the clear wins.
- Green states (own = the current approach, cross = the other approach):
  - Demand = cross_req | ped_pend.
  - Exit to yellow when demand is high and either (own_req == 0 and `cnt` ≥ MIN_GREEN-1) or `cnt` ≥ GREEN_CYCLES-1.
  - With no demand, green rests indefinitely and `cnt` saturates at GREEN_CYCLES-1.
- Yellow lasts exactly YELLOW_CYCLES, then moves to its all-red state.
- All-red lasts exactly ALLRED_CYCLES. It then enters PED_WALK if `ped_pend` is set. Otherwise it enters the cross green: ALLRED_A goes to EW_GREEN, ALLRED_B goes to NS_GREEN.
- PED_WALK lasts exactly WALK_CYCLES. Its exit depends on how it was entered:
  - Entered from ALLRED_A: exit to EW_GREEN.
  - Entered from ALLRED_B: exit to NS_GREEN.
  - This preserves alternation; a 1-bit `next_ew` register records the entry path.
- Outputs are a registered Moore decode of the state (both light outputs are 00 unless stated):
  - NS_GREEN: `ns_light` 10. NS_YELLOW: `ns_light` 01.
  - EW_GREEN: `ew_light` 10. EW_YELLOW: `ew_light` 01.
  - PED_WALK: `walk` 1.
  - All-red states: everything 00 and `walk` 0.
- Manual override:
  - `manual_override` high in any state moves to MANUAL on the next edge.
  - In MANUAL: `ns_light` = `manual_state` (11 maps to 00), `ew_light` = 00, `walk` = 0.
  - `ped_pend` keeps latching during MANUAL.
  - When `manual_override` falls, the next state is ALLRED_B, so clearance always precedes the resumed NS green.
- Reset:
  - The next state is ALLRED_B with `cnt` = 0, `ped_pend` = 0 and `next_ew` = 0.
  - Output values after reset: `ns_light` 00, `ew_light` 00, `walk` 0, `ped_ack` 0, `phase` 5.
  - Reset takes precedence over override and over any in-progress phase, including mid-yellow and mid-walk.

## Timing
- Outputs change on the same edge that enters a state. There is no extra output latency.
- Input to state-change latency is one cycle: an input sampled at edge k is reflected in the outputs after edge k.
- `ped_ack` is high exactly on the first PED_WALK cycle.
- No state ever drives both approaches non-red.
- Green-to-cross-green takes at least YELLOW_CYCLES + ALLRED_CYCLES cycles of non-green.
- Simultaneous events, in priority order: `reset` > `manual_override` > the normal transition.
- When `ns_req` and `ew_req` are both high, the order is strict alternation, with each green capped at GREEN_CYCLES.

## Configuration
- `PED_PHASE_EN` defined: pedestrian logic is present as described above.
- `PED_PHASE_EN` undefined:
  - `ped_req` is ignored.
  - `ped_pend` and `next_ew` are removed.
  - PED_WALK is unreachable.
  - `walk` and `ped_ack` are tied to 0.
  - Demand = cross_req only.

## Test plan
All scenarios use the default parameters.
- **Reset, no requests:** pulse `reset` 1 cycle → `phase` 5 and all lights 00 for 2 cycles, then NS green (`ns_light` 10) held for ≥ 50 cycles, `ew_light` 00.
- **Cross request gapped at minimum green:** `ew_req` high with `ns_req` low from NS green entry → NS green for exactly 8 cycles, NS yellow 4, all-red 2, then `ew_light` 10.
- **Both approaches requesting:** `ns_req` = `ew_req` = 1 continuously → NS green 20, yellow 4, all-red 2, EW green 20, yellow 4, all-red 2, repeating. The period is 52 cycles, with no overlapping non-red lights.
- **Pedestrian request during EW green:** `ped_req` pulse during EW green → after EW yellow and ALLRED_B, `walk` is 1 for 10 cycles, `ped_ack` pulses on the first of them, then `ns_light` 10.
- **Manual override mid-yellow:** assert `manual_override` with `manual_state` 01 mid NS_YELLOW → next cycle `phase` 7, `ns_light` 01, `ew_light` 00. Drive `manual_state` 11 → `ns_light` 00. Release override → 2 all-red cycles, then NS green.
- **Reset mid-walk:** assert `reset` during PED_WALK → `walk` 0 next cycle, `phase` 5. A subsequent run without `ped_req` never enters PED_WALK.
